// File: rtl/cache_coherence_hub.sv
// Coherence hub: round-robin arbitration of per-cache write events and
// broadcast of each accepted write as an invalidate/update snoop to all other caches.
module cache_coherence_hub #(
  parameter int NUM_CACHES  = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int UPDATE_MODE = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CACHES-1:0]                        wr_valid,
  output logic [NUM_CACHES-1:0]                        wr_ready,
  input  logic [NUM_CACHES*ADDR_W-1:0]                 wr_addr,
  input  logic [NUM_CACHES*DATA_W-1:0]                 wr_data,
  output logic [NUM_CACHES-1:0]                        snoop_valid,
  output logic [ADDR_W-1:0]                            snoop_addr,
  output logic [DATA_W-1:0]                            snoop_data,
  output logic                                         snoop_update,
  input  logic [NUM_CACHES-1:0]                        snoop_ack,
  output logic                                         busy,
  output logic [((NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1)-1:0] src_id
);

  localparam int SRC_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NUM_CACHES - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SNOOP = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [NUM_CACHES-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  update_q, update_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;

  logic                  win_found_s;
  logic [SRC_W-1:0]      win_idx_s;
  logic [SRC_W-1:0]      cand_s;
  int                    cand_i_s;
  logic [NUM_CACHES-1:0] win_oh_s;

  // Round-robin search: first valid index upward from last_grant+1, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_i_s    = 0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_CACHES; k++) begin
      cand_i_s = int'(last_grant_q) + k;
      if (cand_i_s >= NUM_CACHES) begin
        cand_i_s = cand_i_s - NUM_CACHES;
      end else begin
        cand_i_s = cand_i_s;
      end
      cand_s = cand_i_s[SRC_W-1:0];
      if (!win_found_s && wr_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic for the IDLE/SNOOP controller.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    data_d       = data_q;
    update_d     = update_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    wr_ready     = '0;
    win_oh_s     = '0;
    if (win_found_s) begin
      win_oh_s[win_idx_s] = 1'b1;
    end else begin
      win_oh_s = '0;
    end
    case (state_q)
      ST_IDLE: begin
        wr_ready = win_oh_s;
        if (win_found_s) begin
          state_d      = ST_SNOOP;
          pending_d    = ~win_oh_s;
          addr_d       = wr_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
          data_d       = (UPDATE_MODE != 0) ? wr_data[int'(win_idx_s)*DATA_W +: DATA_W] : '0;
          update_d     = (UPDATE_MODE != 0);
          src_d        = win_idx_s;
          last_grant_d = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOP: begin
        // Acks on bits that are not pending simply have nothing to clear.
        pending_d = pending_q & ~snoop_ack;
        if (pending_d == '0) begin
          state_d  = ST_IDLE;
          addr_d   = '0;
          data_d   = '0;
          update_d = 1'b0;
        end else begin
          state_d = ST_SNOOP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      update_q     <= 1'b0;
      src_q        <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      update_q     <= update_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign snoop_valid  = pending_q;
  assign snoop_addr   = addr_q;
  assign snoop_data   = data_q;
  assign snoop_update = update_q;
  assign busy         = (state_q == ST_SNOOP);
  assign src_id       = src_q;

endmodule

// File: tb/tb_cache_coherence_hub.sv
// Directed bench for cache_coherence_hub: a 4-cache invalidate hub driven from a
// vector table, plus short hand sequences on a 2-cache update hub and a 1-cache hub.
module tb_cache_coherence_hub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4 caches, write-invalidate
  logic        rst4;
  logic [3:0]  wv4, rdy4, sv4, ack4;
  logic [63:0] addr4, data4;
  logic [15:0] sa4, sd4;
  logic        su4, busy4;
  logic [1:0]  src4;

  // 2 caches, write-update
  logic        rst2;
  logic [1:0]  wv2, rdy2, sv2, ack2;
  logic [31:0] addr2, data2;
  logic [15:0] sa2, sd2;
  logic        su2, busy2;
  logic [0:0]  src2;

  // 1 cache, write-update
  logic        rst1;
  logic [0:0]  wv1, rdy1, sv1, ack1;
  logic [15:0] addr1, data1, sa1, sd1;
  logic        su1, busy1;
  logic [0:0]  src1;

  cache_coherence_hub #(.NUM_CACHES(4), .ADDR_W(16), .DATA_W(16), .UPDATE_MODE(0)) u4 (
    .clk(clk), .rst(rst4), .wr_valid(wv4), .wr_ready(rdy4), .wr_addr(addr4), .wr_data(data4),
    .snoop_valid(sv4), .snoop_addr(sa4), .snoop_data(sd4), .snoop_update(su4),
    .snoop_ack(ack4), .busy(busy4), .src_id(src4));

  cache_coherence_hub #(.NUM_CACHES(2), .ADDR_W(16), .DATA_W(16), .UPDATE_MODE(1)) u2 (
    .clk(clk), .rst(rst2), .wr_valid(wv2), .wr_ready(rdy2), .wr_addr(addr2), .wr_data(data2),
    .snoop_valid(sv2), .snoop_addr(sa2), .snoop_data(sd2), .snoop_update(su2),
    .snoop_ack(ack2), .busy(busy2), .src_id(src2));

  cache_coherence_hub #(.NUM_CACHES(1), .ADDR_W(16), .DATA_W(16), .UPDATE_MODE(1)) u1 (
    .clk(clk), .rst(rst1), .wr_valid(wv1), .wr_ready(rdy1), .wr_addr(addr1), .wr_data(data1),
    .snoop_valid(sv1), .snoop_addr(sa1), .snoop_data(sd1), .snoop_update(su1),
    .snoop_ack(ack1), .busy(busy1), .src_id(src1));

  typedef struct {
    logic        rst;
    logic [3:0]  wv;
    logic [3:0]  ack;
    logic [3:0]  rdy;
    logic [3:0]  sv;
    logic        busy;
    logic [1:0]  src;
    logic [15:0] addr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected before that cycle's edge.
    //            rst   wv       ack      rdy      sv       busy  src    addr
    vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000};
    // cache2 invalidate, acks 3 then 0 then 1, ack[src] held high
    vecs[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 16'h0000};
    vecs[2]  = '{1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b1011, 1'b1, 2'd2, 16'h0042};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0011, 1'b1, 2'd2, 16'h0042};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd2, 16'h0042};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 16'h0000};
    // all valid, immediate acks: grants rotate 3,0,1,2,3,0
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 4'b0000, 1'b0, 2'd2, 16'h0000};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0111, 1'b1, 2'd3, 16'h0043};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd3, 16'h0000};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1110, 1'b1, 2'd0, 16'h0040};
    vecs[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 1'b0, 2'd0, 16'h0000};
    vecs[11] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1101, 1'b1, 2'd1, 16'h0041};
    vecs[12] = '{1'b0, 4'b1111, 4'b1111, 4'b0100, 4'b0000, 1'b0, 2'd1, 16'h0000};
    vecs[13] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b1011, 1'b1, 2'd2, 16'h0042};
    vecs[14] = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 4'b0000, 1'b0, 2'd2, 16'h0000};
    vecs[15] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0111, 1'b1, 2'd3, 16'h0043};
    vecs[16] = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0, 2'd3, 16'h0000};
    // cache0 snoop: no ack, one ack, then rst together with an ack
    vecs[17] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b1110, 1'b1, 2'd0, 16'h0040};
    vecs[18] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b1110, 1'b1, 2'd0, 16'h0040};
    vecs[19] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b1100, 1'b1, 2'd0, 16'h0040};
    // after reset cache0 has priority over cache1, then cache1 is served
    vecs[20] = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0, 16'h0000};
    vecs[21] = '{1'b0, 4'b0010, 4'b1110, 4'b0000, 4'b1110, 1'b1, 2'd0, 16'h0040};
    vecs[22] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 16'h0000};
    vecs[23] = '{1'b0, 4'b0000, 4'b1101, 4'b0000, 4'b1101, 1'b1, 2'd1, 16'h0041};
    vecs[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 16'h0000};

    // cache i address 0x0040+i, data 0x1232+i
    addr4 = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
    data4 = {16'h1235, 16'h1234, 16'h1233, 16'h1232};
    addr2 = {16'h5555, 16'h12A4};
    data2 = {16'h6666, 16'hBEEF};
    addr1 = 16'h00FF;
    data1 = 16'hA5A5;
    wv4 = 4'b0000; ack4 = 4'b0000;
    wv2 = 2'b00;   ack2 = 2'b00;
    wv1 = 1'b0;    ack1 = 1'b0;
    rst4 = 1'b1; rst2 = 1'b1; rst1 = 1'b1;
    tick();
    rst4 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst4 = vecs[i].rst;
      wv4  = vecs[i].wv;
      ack4 = vecs[i].ack;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {20'h0, rdy4, sv4, busy4, src4, sa4, sd4, su4},
            {20'h0, vecs[i].rdy, vecs[i].sv, vecs[i].busy, vecs[i].src, vecs[i].addr, 16'h0000, 1'b0});
      tick();
    end
    wv4 = 4'b0000; ack4 = 4'b0000;

    // 2-cache update mode: idle, grant, snoop with same-cycle ack, back to idle
    @(negedge clk);
    check("u2_idle", {rdy2, sv2, sa2, sd2, su2, busy2, src2},
          {2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0});
    tick();
    wv2 = 2'b01;
    @(negedge clk);
    check("u2_grant", {rdy2, sv2, busy2}, {2'b01, 2'b00, 1'b0});
    tick();
    wv2  = 2'b00;
    ack2 = 2'b10;
    @(negedge clk);
    check("u2_snoop", {rdy2, sv2, sa2, sd2, su2, busy2, src2},
          {2'b00, 2'b10, 16'h12A4, 16'hBEEF, 1'b1, 1'b1, 1'b0});
    tick();
    ack2 = 2'b00;
    @(negedge clk);
    check("u2_done", {rdy2, sv2, sa2, sd2, su2, busy2},
          {2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0});
    tick();

    // 1-cache: SNOOP lasts one cycle with no targets
    wv1 = 1'b1;
    @(negedge clk);
    check("u1_grant", {rdy1, sv1, busy1}, {1'b1, 1'b0, 1'b0});
    tick();
    wv1 = 1'b0;
    @(negedge clk);
    check("u1_snoop", {rdy1, sv1, sa1, sd1, su1, busy1, src1},
          {1'b0, 1'b0, 16'h00FF, 16'hA5A5, 1'b1, 1'b1, 1'b0});
    tick();
    @(negedge clk);
    check("u1_done", {rdy1, sv1, sa1, sd1, su1, busy1},
          {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_coherence_hub.md
Name: cache_coherence_hub

Overview:
- Parametrised successor to the two-cache coherence path.
- Collects write events from NUM_CACHES private caches and serialises them with a round-robin arbiter.
- Broadcasts each accepted write to every other cache as an invalidate or an update snoop, then waits until every target cache has acknowledged.
- Sits between the per-core cache state machines and the shared memory path; caches service snoops with priority over CPU requests.

Parameters:
NUM_CACHES, 2, number of cache channels (1..8)
ADDR_W, 16, address width (tag 8, index 7, offset 1 at default)
DATA_W, 16, data width of one write event
UPDATE_MODE, 0, 0 = write-invalidate snoops, 1 = write-update snoops carrying data

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, synchronous, active-high
wr_valid  in  NUM_CACHES  per-cache write event pending
wr_ready  out  NUM_CACHES  per-cache accept; transfer when valid&ready at clk edge
wr_addr  in  NUM_CACHES*ADDR_W  packed addresses, cache i at [i*ADDR_W +: ADDR_W]
wr_data  in  NUM_CACHES*DATA_W  packed data, same packing
snoop_valid  out  NUM_CACHES  per-target snoop request (never set for source cache)
snoop_addr  out  ADDR_W  address of current snoop, shared by all targets
snoop_data  out  DATA_W  data of current snoop (0 when UPDATE_MODE=0)
snoop_update  out  1  1 = update, 0 = invalidate; equals UPDATE_MODE during a snoop
snoop_ack  in  NUM_CACHES  per-target acknowledge
busy  out  1  high in any non-IDLE state
src_id  out  $clog2(NUM_CACHES) (min 1)  index of cache whose write is being broadcast

Behaviour:
- Reset values (rst high at clk edge):
  - state=IDLE; wr_ready=0; snoop_valid=0; snoop_addr=0; snoop_data=0; snoop_update=0; busy=0; src_id=0; pending=0.
  - Round-robin pointer set so cache 0 has highest priority next.
- States: IDLE, SNOOP.
- IDLE:
  - wr_ready is combinational: one-hot of the arbiter winner among wr_valid; all zero if none valid.
  - Winner = first valid index searching upward (with wrap) from last_grant+1.
  - On the edge where winner valid&ready: latch addr and data (data forced 0 if UPDATE_MODE=0); src_id=winner; last_grant=winner; pending = all-ones & ~onehot(winner); go to SNOOP.
- SNOOP:
  - wr_ready=0; busy=1; snoop_valid=pending; snoop_addr, snoop_data and src_id held stable.
  - Each edge: pending <= pending & ~snoop_ack. An ack counts in the same cycle snoop_valid rises.
  - snoop_valid[i] drops the cycle after ack[i] is sampled; partial acks across cycles are accumulated.
  - Ack on a bit with snoop_valid=0 is ignored.
  - When pending & ~snoop_ack == 0 at an edge, go to IDLE. Snoop outputs clear to 0 (snoop_update=0) and busy drops the next cycle.
  - NUM_CACHES=1: pending=0, so SNOOP lasts exactly one cycle with snoop_valid=0.
- Throughput and latency:
  - Minimum 2 cycles per write: grant cycle in IDLE, then SNOOP with all acks in its first cycle.
  - A new grant may occur in the first IDLE cycle after return.
- Fairness:
  - A cache just granted has lowest priority next arbitration.
  - Any continuously asserted wr_valid is granted within NUM_CACHES transactions.
- The requesting cache must hold wr_valid, addr and data stable until ready; the hub does not check this.
- Reset mid-SNOOP: abandon the transaction and all pending acks; outputs take reset values on the next cycle; the write is lost (caches re-issue).
- Simultaneous events: valid on all channels picks by pointer only. An ack and rst in the same cycle: rst wins.

Test Plan:
- Reset then idle: all outputs 0, busy=0, wr_ready=0 with no wr_valid.
- Single write, UPDATE_MODE=1, NUM_CACHES=2: cache0 addr 16'h12A4 data 16'hBEEF → wr_ready=2'b01 for one cycle. Next cycle snoop_valid=2'b10, addr 12A4, data BEEF, update=1, src_id=0. Ack[1] same cycle → IDLE the following cycle.
- Invalidate mode, NUM_CACHES=4: cache2 writes addr 16'h0042 data 16'h1234 → snoop_valid=4'b1011, snoop_data=0, update=0. Acks for 3, then 0, then 1 on successive cycles → snoop_valid 1011→0011→0010→0000. busy falls one cycle after the final ack.
- Round-robin, NUM_CACHES=4, all wr_valid held high with immediate acks: grant order 0,1,2,3,0; no repeat while others wait.
- Ack on a non-targeted or already-acked bit (e.g. ack[src] high throughout): no effect on pending or completion timing.
- rst asserted during SNOOP with 2 of 3 acks outstanding: next cycle state IDLE, snoop_valid=0, busy=0. A subsequent write from cache1 is arbitrated with cache0 priority.
